// File: rtl/bird_launch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bird_launch_ctrl_if
// Description : Signal bundle between the keypad/game-state logic, the bird
//               launch sequencer and the bird motion block.
//               slave  - the sequencer side (bird_launch_ctrl)
//               master - the environment driving frame, key and game inputs
//               Signals:
//                 startOfFrame  one-cycle pulse per frame
//                 launchKey     synchronized launch button level
//                 restart       level restart request (level-sensitive)
//                 levelCleared  all targets destroyed (level-sensitive)
//                 displayBird   bird-in-flight flag from the motion block
//                 showBird      launch request to the motion block
//                 birdsLeft     birds not yet consumed (4 bits)
//                 shotActive    high from launch acceptance until landing
//                 levelWin      sticky win flag
//                 gameOver      sticky loss flag
// Revision    : 1.0 - initial release
// ============================================================================
interface bird_launch_ctrl_if;
    logic       startOfFrame;
    logic       launchKey;
    logic       restart;
    logic       levelCleared;
    logic       displayBird;
    logic       showBird;
    logic [3:0] birdsLeft;
    logic       shotActive;
    logic       levelWin;
    logic       gameOver;

    modport slave (
        input  startOfFrame, launchKey, restart, levelCleared, displayBird,
        output showBird, birdsLeft, shotActive, levelWin, gameOver
    );

    modport master (
        output startOfFrame, launchKey, restart, levelCleared, displayBird,
        input  showBird, birdsLeft, shotActive, levelWin, gameOver
    );
endinterface
`default_nettype wire

// File: rtl/bird_launch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bird_launch_ctrl
// Description : Launch sequencer for the bird motion block. Holds the bird
//               supply for a level, turns a launch key press into a held
//               showBird request, tracks each shot until landing, enforces a
//               reload delay and declares the level won or lost.
//               Ports:
//                 clk     system clock
//                 resetN  asynchronous active-low reset
//                 bus     bird_launch_ctrl_if.slave (frame/key/game inputs,
//                         motion-block handshake, status outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module bird_launch_ctrl #(
    parameter int NUM_BIRDS     = 3,
    parameter int RELOAD_FRAMES = 15,
    parameter int ARM_TIMEOUT   = 8
) (
    input  wire logic             clk,
    input  wire logic             resetN,
    bird_launch_ctrl_if.slave     bus
);

    localparam logic [3:0] c_NUM_BIRDS     = 4'(NUM_BIRDS);
    localparam logic [7:0] c_RELOAD_FRAMES = 8'(RELOAD_FRAMES);
    localparam logic [7:0] c_ARM_TIMEOUT   = 8'(ARM_TIMEOUT);

    typedef enum logic [2:0] {
        READY_ST    = 3'd0,
        ARM_ST      = 3'd1,
        FLIGHT_ST   = 3'd2,
        COOLDOWN_ST = 3'd3,
        WIN_ST      = 3'd4,
        LOSE_ST     = 3'd5
    } state_t;

    state_t     state_q,  state_d;
    logic [7:0] cnt_q,    cnt_d;
    logic [3:0] birds_q,  birds_d;
    logic       show_q,   show_d;
    logic       active_q, active_d;
    logic       win_q,    win_d;
    logic       over_q,   over_d;
    logic       key_q,    key_d;
    logic       disp_q,   disp_d;
    logic       fall_q,   fall_d;

    logic       w_launch_press;
    logic [7:0] w_cnt_dec;
    logic       w_terminal;

    always_comb begin
        // History registers follow their inputs every clock.
        key_d  = bus.launchKey;
        disp_d = bus.displayBird;
        // The landing edge is registered before the FSM acts on it, so
        // shotActive drops two clocks after displayBird falls.
        fall_d = disp_q & ~bus.displayBird;

        w_launch_press = bus.launchKey & ~key_q;
        w_cnt_dec      = (cnt_q != 8'd0) ? (cnt_q - 8'd1) : 8'd0;
        w_terminal     = (state_q == WIN_ST) || (state_q == LOSE_ST);

        state_d  = state_q;
        cnt_d    = cnt_q;
        birds_d  = birds_q;
        show_d   = show_q;
        active_d = active_q;
        win_d    = win_q;
        over_d   = over_q;

        case (state_q)
            READY_ST: begin
                if (w_launch_press && (birds_q != 4'd0)) begin
                    state_d = ARM_ST;
                    cnt_d   = c_ARM_TIMEOUT;
                    show_d  = 1'b1;
                end
            end
            ARM_ST: begin
                // Acceptance wins over a timeout pulse in the same cycle.
                if (bus.displayBird) begin
                    state_d  = FLIGHT_ST;
                    show_d   = 1'b0;
                    active_d = 1'b1;
                    if (birds_q != 4'd0) begin
                        birds_d = birds_q - 4'd1;
                    end
                end else if (bus.startOfFrame) begin
                    cnt_d = w_cnt_dec;
                    if (w_cnt_dec == 8'd0) begin
                        state_d = READY_ST;
                        show_d  = 1'b0;
                    end
                end
            end
            FLIGHT_ST: begin
                if (fall_q) begin
                    active_d = 1'b0;
                    if (birds_q == 4'd0) begin
                        state_d = LOSE_ST;
                        over_d  = 1'b1;
                    end else begin
                        state_d = COOLDOWN_ST;
                        cnt_d   = c_RELOAD_FRAMES;
                    end
                end
            end
            COOLDOWN_ST: begin
                // Key presses are simply ignored here; only the frame count
                // decides when READY_ST is re-entered.
                if (bus.startOfFrame) begin
                    cnt_d = w_cnt_dec;
                    if (w_cnt_dec == 8'd0) begin
                        state_d = READY_ST;
                    end
                end
            end
            WIN_ST: begin
                win_d = 1'b1;
                // A bird still in the air when the level was won lands here.
                if (fall_q) begin
                    active_d = 1'b0;
                end
            end
            LOSE_ST: begin
                over_d = 1'b1;
            end
            default: begin
                state_d = READY_ST;
            end
        endcase

        // Winning overrides any transition computed above, including the
        // one into LOSE_ST; the in-flight shot keeps its landing tracking.
        if (bus.levelCleared && !w_terminal) begin
            state_d  = WIN_ST;
            cnt_d    = cnt_q;
            birds_d  = birds_q;
            show_d   = 1'b0;
            active_d = active_q & ~fall_q;
            win_d    = 1'b1;
            over_d   = over_q;
        end

        if (bus.restart) begin
            state_d  = READY_ST;
            cnt_d    = 8'd0;
            birds_d  = c_NUM_BIRDS;
            show_d   = 1'b0;
            active_d = 1'b0;
            win_d    = 1'b0;
            over_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= READY_ST;
            cnt_q    <= 8'd0;
            birds_q  <= c_NUM_BIRDS;
            show_q   <= 1'b0;
            active_q <= 1'b0;
            win_q    <= 1'b0;
            over_q   <= 1'b0;
            key_q    <= 1'b0;
            disp_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            birds_q  <= birds_d;
            show_q   <= show_d;
            active_q <= active_d;
            win_q    <= win_d;
            over_q   <= over_d;
            key_q    <= key_d;
            disp_q   <= disp_d;
            fall_q   <= fall_d;
        end
    end

    assign bus.showBird   = show_q;
    assign bus.birdsLeft  = birds_q;
    assign bus.shotActive = active_q;
    assign bus.levelWin   = win_q;
    assign bus.gameOver   = over_q;

endmodule
`default_nettype wire

// File: tb/tb_bird_launch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bird_launch_ctrl
// Description : Directed self-checking bench for bird_launch_ctrl with the
//               default parameters (3 birds, 15 reload frames, 8 arm frames).
//               Inputs change on the falling clock edge, outputs are
//               checked on the falling edge; one frame = 4 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bird_launch_ctrl;

    logic clk;
    logic resetN;
    int   n_total;
    int   n_pass;

    bird_launch_ctrl_if bif ();

    bird_launch_ctrl #(
        .NUM_BIRDS     (3),
        .RELOAD_FRAMES (15),
        .ARM_TIMEOUT   (8)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One startOfFrame pulse followed by three idle clocks.
    task automatic frame(input int n);
        for (int i = 0; i < n; i++) begin
            bif.startOfFrame = 1'b1;
            @(negedge clk);
            bif.startOfFrame = 1'b0;
            cyc(3);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        resetN  = 1'b0;
        bif.startOfFrame = 1'b0;
        bif.launchKey    = 1'b0;
        bif.restart      = 1'b0;
        bif.levelCleared = 1'b0;
        bif.displayBird  = 1'b0;
        cyc(2);
        chk("reset_show",   32'(bif.showBird),   32'd0);
        chk("reset_birds",  32'(bif.birdsLeft),  32'd3);
        chk("reset_active", 32'(bif.shotActive), 32'd0);
        chk("reset_win",    32'(bif.levelWin),   32'd0);
        chk("reset_over",   32'(bif.gameOver),   32'd0);
        resetN = 1'b1;
        cyc(2);

        // Shot A: normal launch, accepted 5 frames after the press.
        bif.launchKey = 1'b1;
        cyc(1);
        chk("a_show_on", 32'(bif.showBird), 32'd1);
        bif.launchKey = 1'b0;
        frame(5);
        chk("a_show_held", 32'(bif.showBird), 32'd1);
        bif.displayBird = 1'b1;
        cyc(1);
        chk("a_show_off", 32'(bif.showBird),   32'd0);
        chk("a_active",   32'(bif.shotActive), 32'd1);
        chk("a_birds",    32'(bif.birdsLeft),  32'd2);
        cyc(3);
        bif.displayBird = 1'b0;
        cyc(1);
        chk("a_active_1clk", 32'(bif.shotActive), 32'd1);
        cyc(1);
        chk("a_active_2clk", 32'(bif.shotActive), 32'd0);
        // Cooldown: a press after 14 frames is discarded, READY after 15.
        frame(14);
        bif.launchKey = 1'b1;
        cyc(1);
        chk("cool_press_ignored", 32'(bif.showBird), 32'd0);
        bif.launchKey = 1'b0;
        cyc(1);
        frame(1);
        bif.launchKey = 1'b1;
        cyc(1);
        chk("cool_done_press", 32'(bif.showBird), 32'd1);
        bif.launchKey = 1'b0;

        // Shot B: arm timeout, bird not consumed.
        frame(7);
        chk("b_show_7frames", 32'(bif.showBird), 32'd1);
        bif.startOfFrame = 1'b1;
        cyc(1);
        bif.startOfFrame = 1'b0;
        chk("b_timeout_show",  32'(bif.showBird),  32'd0);
        chk("b_timeout_birds", 32'(bif.birdsLeft), 32'd2);
        cyc(2);

        // Shot C: key held from press through landing and cooldown.
        bif.launchKey = 1'b1;
        cyc(1);
        chk("c_show_on", 32'(bif.showBird), 32'd1);
        bif.displayBird = 1'b1;
        cyc(1);
        chk("c_birds",  32'(bif.birdsLeft),  32'd1);
        chk("c_active", 32'(bif.shotActive), 32'd1);
        bif.displayBird = 1'b0;
        cyc(2);
        chk("c_landed", 32'(bif.shotActive), 32'd0);
        frame(15);
        cyc(4);
        chk("c_held_no_retrigger", 32'(bif.showBird), 32'd0);
        bif.launchKey = 1'b0;
        cyc(1);
        bif.launchKey = 1'b1;
        cyc(1);
        chk("d_show_on", 32'(bif.showBird), 32'd1);
        bif.launchKey = 1'b0;

        // Shot D: last bird, landing leads to loss.
        bif.displayBird = 1'b1;
        cyc(1);
        chk("d_birds", 32'(bif.birdsLeft), 32'd0);
        bif.displayBird = 1'b0;
        cyc(2);
        chk("d_active", 32'(bif.shotActive), 32'd0);
        chk("d_over",   32'(bif.gameOver),   32'd1);
        chk("d_win",    32'(bif.levelWin),   32'd0);
        bif.launchKey = 1'b1;
        cyc(1);
        bif.launchKey = 1'b0;
        cyc(1);
        chk("lose_no_launch", 32'(bif.showBird), 32'd0);
        chk("lose_sticky",    32'(bif.gameOver), 32'd1);

        // Restart beats levelCleared in LOSE_ST.
        bif.restart      = 1'b1;
        bif.levelCleared = 1'b1;
        cyc(1);
        bif.restart      = 1'b0;
        bif.levelCleared = 1'b0;
        chk("rs_birds", 32'(bif.birdsLeft), 32'd3);
        chk("rs_win",   32'(bif.levelWin),  32'd0);
        chk("rs_over",  32'(bif.gameOver),  32'd0);
        cyc(1);

        // Shot E: level cleared mid-flight.
        bif.launchKey = 1'b1;
        cyc(1);
        bif.launchKey = 1'b0;
        bif.displayBird = 1'b1;
        cyc(1);
        chk("e_birds", 32'(bif.birdsLeft), 32'd2);
        bif.levelCleared = 1'b1;
        cyc(1);
        bif.levelCleared = 1'b0;
        chk("e_win",         32'(bif.levelWin),   32'd1);
        chk("e_active_kept", 32'(bif.shotActive), 32'd1);
        bif.displayBird = 1'b0;
        cyc(2);
        chk("e_active_land", 32'(bif.shotActive), 32'd0);
        chk("e_over",        32'(bif.gameOver),   32'd0);
        chk("e_win_sticky",  32'(bif.levelWin),   32'd1);
        bif.launchKey = 1'b1;
        cyc(1);
        bif.launchKey = 1'b0;
        chk("win_no_launch", 32'(bif.showBird), 32'd0);
        bif.restart = 1'b1;
        cyc(1);
        bif.restart = 1'b0;
        chk("rs2_win",   32'(bif.levelWin),  32'd0);
        chk("rs2_birds", 32'(bif.birdsLeft), 32'd3);
        cyc(1);

        // Asynchronous reset while armed.
        bif.launchKey = 1'b1;
        cyc(1);
        bif.launchKey = 1'b0;
        chk("f_show_on", 32'(bif.showBird), 32'd1);
        #2 resetN = 1'b0;
        #1;
        chk("async_show",  32'(bif.showBird),  32'd0);
        chk("async_birds", 32'(bif.birdsLeft), 32'd3);
        cyc(1);
        resetN = 1'b1;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
